// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of one mux8 slot with release, withdrawal and hold-timeout
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] grant,
  output logic [2:0] select,
  output logic       valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t     state;
  logic [2:0] ptr, base, win, idx;
  logic [7:0] cnt;
  logic       found, expire, term;
  always_comb begin
    expire = (MAX_HOLD != 0) && (cnt == 8'(MAX_HOLD - 1));
    term   = (state == GRANTED) && (rel || !req[select] || expire);
    base   = term ? select + 3'd1 : ptr;
    found  = 1'b0;
    win    = base;
    idx    = base;
    // Scan from farthest to nearest so the nearest set bit after base wins;
    // a withdrawn owner's bit is already clear, so no explicit mask is needed.
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      select  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      timeout <= term && expire && !rel && req[select];
      if (term) ptr <= select + 3'd1;
      if (state == IDLE || term) begin
        if (found) begin
          state  <= GRANTED;
          grant  <= 8'b1 << win;
          select <= win;
          valid  <= 1'b1;
          cnt    <= '0;
        end else begin
          state <= IDLE;
          grant <= '0;
          valid <= 1'b0;
        end
      end else begin
        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed scenario tasks for mux8_rr_arbiter with MAX_HOLD=4
module tb_mux8_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       rel = 1'b0;
  logic [7:0] grant;
  logic [2:0] select;
  logic       valid;
  logic       timeout;
  int total = 0;
  int bad = 0;
  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .grant(grant), .select(select), .valid(valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0;
    rel = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    rel = 1'b0;
    #12;
    total++;
    if ({grant, select, valid, timeout} !== 13'd0) begin
      bad++;
      $display("FAIL reset: grant=%h select=%0d valid=%b timeout=%b, want all zero", grant, select, valid, timeout);
    end
    rst_n = 1'b1;
    step();
    req = 8'h01;
    step();
    total++;
    if (grant !== 8'h01 || select !== 3'd0 || valid !== 1'b1) begin
      bad++;
      $display("FAIL first_grant: grant=%h select=%0d valid=%b, want 01 0 1", grant, select, valid);
    end
    req = 8'h00;
    rel = 1'b1;
    step();
    rel = 1'b0;
    total++;
    if (grant !== 8'h00 || valid !== 1'b0) begin
      bad++;
      $display("FAIL release_idle: grant=%h valid=%b, want 00 0", grant, valid);
    end
    req = 8'h03;
    step();
    total++;
    if (grant !== 8'h02 || select !== 3'd1) begin
      bad++;
      $display("FAIL ptr_after_release: grant=%h select=%0d, want 02 1", grant, select);
    end
  endtask
  task automatic test_rotate();
    do_reset();
    req = 8'hFF;
    step();
    total++;
    if (grant !== 8'h01) begin
      bad++;
      $display("FAIL rotate_start: grant=%h, want 01", grant);
    end
    rel = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (grant !== (8'h01 << (k % 8)) || select !== 3'(k % 8) || valid !== 1'b1 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL rotate_%0d: grant=%h select=%0d valid=%b timeout=%b, want %h %0d 1 0",
                 k, grant, select, valid, timeout, 8'h01 << (k % 8), k % 8);
      end
    end
    rel = 1'b0;
  endtask
  task automatic test_hold_timeout();
    logic [7:0] eg;
    do_reset();
    req = 8'h05;
    for (int k = 0; k < 12; k++) begin
      step();
      eg = ((k / 4) % 2 == 1) ? 8'h04 : 8'h01;
      total++;
      if (grant !== eg || valid !== 1'b1 || timeout !== (k % 4 == 0 && k > 0)) begin
        bad++;
        $display("FAIL hold_%0d: grant=%h valid=%b timeout=%b, want %h 1 %b",
                 k, grant, valid, timeout, eg, (k % 4 == 0 && k > 0));
      end
    end
  endtask
  task automatic test_sole_timeout();
    do_reset();
    req = 8'h08;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (grant !== 8'h08 || select !== 3'd3 || valid !== 1'b1 || timeout !== (k % 4 == 0 && k > 0)) begin
        bad++;
        $display("FAIL sole_%0d: grant=%h select=%0d valid=%b timeout=%b, want 08 3 1 %b",
                 k, grant, select, valid, timeout, (k % 4 == 0 && k > 0));
      end
    end
  endtask
  task automatic test_withdraw();
    do_reset();
    req = 8'h20;
    step();
    req = 8'h21;
    step();
    total++;
    if (grant !== 8'h20 || select !== 3'd5) begin
      bad++;
      $display("FAIL withdraw_hold: grant=%h select=%0d, want 20 5", grant, select);
    end
    req = 8'h01;
    step();
    total++;
    if (grant !== 8'h01 || select !== 3'd0 || valid !== 1'b1 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL withdraw_wrap: grant=%h select=%0d valid=%b timeout=%b, want 01 0 1 0", grant, select, valid, timeout);
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    req = 8'h10;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (grant !== 8'h00 || valid !== 1'b0 || select !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: grant=%h valid=%b select=%0d, want 00 0 0", grant, valid, select);
    end
    req = 8'h80;
    #1;
    rst_n = 1'b1;
    step();
    total++;
    if (grant !== 8'h80 || select !== 3'd7 || valid !== 1'b1) begin
      bad++;
      $display("FAIL after_reset: grant=%h select=%0d valid=%b, want 80 7 1", grant, select, valid);
    end
  endtask
  task automatic test_coincident();
    do_reset();
    req = 8'h03;
    for (int k = 0; k < 4; k++) step();
    total++;
    if (grant !== 8'h01 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL coinc_hold: grant=%h timeout=%b, want 01 0", grant, timeout);
    end
    rel = 1'b1;
    step();
    rel = 1'b0;
    total++;
    if (grant !== 8'h02 || select !== 3'd1 || valid !== 1'b1 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL coinc_handoff: grant=%h select=%0d valid=%b timeout=%b, want 02 1 1 0", grant, select, valid, timeout);
    end
  endtask
  task automatic test_idle_release();
    do_reset();
    rel = 1'b1;
    step();
    total++;
    if (valid !== 1'b0 || grant !== 8'h00) begin
      bad++;
      $display("FAIL idle_release: grant=%h valid=%b, want 00 0", grant, valid);
    end
    req = 8'h04;
    step();
    rel = 1'b0;
    total++;
    if (grant !== 8'h04 || select !== 3'd2 || valid !== 1'b1) begin
      bad++;
      $display("FAIL idle_release_grant: grant=%h select=%0d valid=%b, want 04 2 1", grant, select, valid);
    end
  endtask
  initial begin
    test_reset();
    test_rotate();
    test_hold_timeout();
    test_sole_timeout();
    test_withdraw();
    test_async_reset();
    test_coincident();
    test_idle_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
